tl_ul_a_arbiter_2to1: RTL and testbench

Two-master TileLink-UL arbiter that shares the single upstream port of the TL fragmenter wrapper between two requesters, e.g. core data port and debug/DMA port. Arbitrates the A channel round-robin and holds the grant for every beat of a multi-beat Put. Tags the downstream source with a master-index MSB and routes D responses back by that bit. Sits directly in front of the fragmenter wrapper.

---
 rtl/tl_ul_arb_pkg.sv | 90 +++++++++
 rtl/tl_ul_a_arbiter_2to1_rr.sv | 51 +++++
 rtl/tl_ul_a_arbiter_2to1.sv | 230 +++++++++++++++++++++++
 tb/tb_tl_ul_a_arbiter_2to1.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_ul_arb_pkg.sv
// tl_ul_arb_pkg
//   Shared definitions for the two-master TileLink-UL A-channel arbiter:
//   opcode constants, arbiter FSM state type, bit-field widths and offset
//   helpers for the packed A/D buses, and the beats-per-message helpers.
//
//   A bus layout (MSB -> LSB): opcode[3] param[3] size[3] source address mask data
//   D bus layout (MSB -> LSB): opcode[3] param[2] size[3] source denied[1] data
package tl_ul_arb_pkg;

  localparam logic [2:0] OP_PUT_FULL        = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] OP_GET             = 3'd4;
  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

  localparam int OPC_W     = 3;
  localparam int A_PARAM_W = 3;
  localparam int D_PARAM_W = 2;
  localparam int SIZE_W    = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  // ---------------- A channel field offsets ----------------
  function automatic int a_src_lsb(input int addr_w, input int data_w);
    return data_w + data_w / 8 + addr_w;
  endfunction

  function automatic int a_size_lsb(input int src_w, input int addr_w, input int data_w);
    return a_src_lsb(addr_w, data_w) + src_w;
  endfunction

  function automatic int a_opc_lsb(input int src_w, input int addr_w, input int data_w);
    return a_size_lsb(src_w, addr_w, data_w) + SIZE_W + A_PARAM_W;
  endfunction

  function automatic int a_w(input int src_w, input int addr_w, input int data_w);
    return a_opc_lsb(src_w, addr_w, data_w) + OPC_W;
  endfunction

  // ---------------- D channel field offsets ----------------
  function automatic int d_src_lsb(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int d_size_lsb(input int src_w, input int data_w);
    return d_src_lsb(data_w) + src_w;
  endfunction

  function automatic int d_opc_lsb(input int src_w, input int data_w);
    return d_size_lsb(src_w, data_w) + SIZE_W + D_PARAM_W;
  endfunction

  function automatic int d_w(input int src_w, input int data_w);
    return d_opc_lsb(src_w, data_w) + OPC_W;
  endfunction

  // Number of A beats carried by one request. Only Puts larger than one
  // beat span several beats; oversize requests are passed as one beat and
  // rejected further downstream.
  function automatic logic [7:0] beats_of(input logic [2:0] opcode,
                                          input logic [2:0] size,
                                          input int         lg_beat,
                                          input int         max_size);
    logic [7:0] n;
    n = 8'd1;
    if ((opcode == OP_PUT_FULL || opcode == OP_PUT_PARTIAL) &&
        int'(size) > lg_beat && int'(size) <= max_size) begin
      n = 8'd1 << (int'(size) - lg_beat);
    end
    return n;
  endfunction

  // Number of D beats in one response: only AccessAckData spans beats.
  function automatic logic [7:0] resp_beats_of(input logic [2:0] opcode,
                                               input logic [2:0] size,
                                               input int         lg_beat,
                                               input int         max_size);
    logic [7:0] n;
    n = 8'd1;
    if (opcode == OP_ACCESS_ACK_DATA &&
        int'(size) > lg_beat && int'(size) <= max_size) begin
      n = 8'd1 << (int'(size) - lg_beat);
    end
    return n;
  endfunction

endpackage

// File: rtl/tl_ul_a_arbiter_2to1_rr.sv
// tl_rr_arb2
//   Two-input round-robin grant selector with its own priority pointer.
//   clk_i/rst_ni : clock, asynchronous active-low reset
//   req_i        : per-input eligible request
//   hold_i       : keep the previous grant (a stalled beat is pending)
//   hold_idx_i   : grant to keep while hold_i is set
//   adv_i        : a request completed this cycle; move priority away
//   done_idx_i   : index of the master whose request completed
//   gnt_o        : selected index (pointer value when nobody requests)
module tl_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       hold_i,
  input  logic       hold_idx_i,
  input  logic       adv_i,
  input  logic       done_idx_i,
  output logic       gnt_o
);

  logic rr_ptr_q, rr_ptr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (adv_i) begin
      rr_ptr_d = ~done_idx_i;
    end
  end

  always_comb begin
    gnt_o = rr_ptr_q;
    if (hold_i) begin
      gnt_o = hold_idx_i;
    end else begin
      unique case (req_i)
        2'b01:   gnt_o = 1'b0;
        2'b10:   gnt_o = 1'b1;
        default: gnt_o = rr_ptr_q;
      endcase
    end
  end

endmodule

// File: rtl/tl_ul_a_arbiter_2to1.sv
// tl_ul_a_arbiter_2to1
//   Shares one TileLink-UL upstream port between two masters. The A channel
//   is arbitrated round-robin with the grant locked for every beat of a
//   multi-beat Put; the downstream source gets the master index as MSB and
//   D responses are steered back by that bit, combinationally.
//
//   clock/reset         : rising-edge clock, asynchronous active-low reset
//   m_a_valid/ready/bits: per-master A channel (bit/row i = master i)
//   s_a_valid/ready/bits: arbitrated A channel, source = {grant, source}
//   s_d_valid/ready/bits: D channel from downstream
//   m_d_valid/ready/bits: per-master D channel, source MSB removed
//   busy                : burst locked or (with limit) requests outstanding
//
//   Optional build macro TL_ARB_INFLIGHT_LIMIT_EN: per-master outstanding
//   counters; a master with MAX_INFLIGHT requests open is not arbitrated.
module tl_ul_a_arbiter_2to1
  import tl_ul_arb_pkg::*;
#(
  parameter  int ADDR_W       = 26,
  parameter  int DATA_W       = 32,
  parameter  int SRC_W        = 2,
  parameter  int MAX_SIZE     = 6,
  parameter  int MAX_INFLIGHT = 4,
  localparam int A_W          = a_w(SRC_W, ADDR_W, DATA_W),
  localparam int SA_W         = A_W + 1,
  localparam int MD_W         = d_w(SRC_W, DATA_W),
  localparam int SD_W         = d_w(SRC_W + 1, DATA_W)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            m_a_valid,
  output logic [1:0]            m_a_ready,
  input  logic [1:0][A_W-1:0]   m_a_bits,
  output logic                  s_a_valid,
  input  logic                  s_a_ready,
  output logic [SA_W-1:0]       s_a_bits,
  input  logic                  s_d_valid,
  output logic                  s_d_ready,
  input  logic [SD_W-1:0]       s_d_bits,
  output logic [1:0]            m_d_valid,
  input  logic [1:0]            m_d_ready,
  output logic [1:0][MD_W-1:0]  m_d_bits,
  output logic                  busy
);

  localparam int LGB        = $clog2(DATA_W / 8);
  localparam int CNT_W      = (MAX_SIZE > LGB) ? (MAX_SIZE - LGB) : 1;
  localparam int A_SIZE_LSB = a_size_lsb(SRC_W, ADDR_W, DATA_W);
  localparam int A_OPC_LSB  = a_opc_lsb(SRC_W, ADDR_W, DATA_W);
  localparam int D_MSB      = d_src_lsb(DATA_W) + SRC_W;

  if (MAX_INFLIGHT < 1 || DATA_W < 8 || MAX_SIZE > 7) begin : g_bad_cfg
    $error("tl_ul_a_arbiter_2to1: unsupported parameter set");
  end

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              lock_idx_q, lock_idx_d;
  logic              stall_q, stall_d;
  logic              stall_idx_q, stall_idx_d;

  logic [1:0]        full;
  logic [1:0]        eligible;
  logic              arb_gnt;
  logic              grant_idx;
  logic              a_hs;
  logic              a_done;
  logic [A_W-1:0]    a_sel;
  logic [2:0]        a_opc;
  logic [2:0]        a_size;
  logic [7:0]        a_beats;
  logic              d_msb;

  // In LOCK the latched master owns the port regardless of the limiter.
  assign eligible = (state_q == ST_LOCK) ? m_a_valid : (m_a_valid & ~full);

  tl_rr_arb2 u_rr (
    .clk_i      (clock),
    .rst_ni     (reset),
    .req_i      (eligible),
    .hold_i     (stall_q),
    .hold_idx_i (stall_idx_q),
    .adv_i      (a_done),
    .done_idx_i (grant_idx),
    .gnt_o      (arb_gnt)
  );

  assign grant_idx = (state_q == ST_LOCK) ? lock_idx_q : arb_gnt;
  assign a_sel     = m_a_bits[grant_idx];
  assign a_opc     = a_sel[A_OPC_LSB +: 3];
  assign a_size    = a_sel[A_SIZE_LSB +: 3];
  assign a_beats   = beats_of(a_opc, a_size, LGB, MAX_SIZE);

  assign s_a_valid = eligible[grant_idx];
  assign s_a_bits  = {a_sel[A_W-1:A_SIZE_LSB], grant_idx, a_sel[A_SIZE_LSB-1:0]};
  assign a_hs      = s_a_valid & s_a_ready;

  // A masked master never sees ready, so it cannot slip a beat through.
  always_comb begin
    m_a_ready = 2'b00;
    if (s_a_ready && (state_q == ST_LOCK || !full[grant_idx])) begin
      m_a_ready = 2'b01 << grant_idx;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      lock_idx_q  <= 1'b0;
      stall_q     <= 1'b0;
      stall_idx_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      lock_idx_q  <= lock_idx_d;
      stall_q     <= stall_d;
      stall_idx_q <= stall_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    lock_idx_d  = lock_idx_q;
    a_done      = 1'b0;
    // Remember an offered-but-unaccepted beat so the grant cannot move
    // away from it even if the other master starts requesting.
    stall_d     = (state_q == ST_IDLE) && s_a_valid && !s_a_ready;
    stall_idx_d = grant_idx;
    unique case (state_q)
      ST_IDLE: begin
        if (a_hs) begin
          if (a_beats > 8'd1) begin
            state_d    = ST_LOCK;
            lock_idx_d = grant_idx;
            beat_cnt_d = CNT_W'(a_beats - 8'd1);
          end else begin
            a_done = 1'b1;
          end
        end
      end
      ST_LOCK: begin
        if (a_hs) begin
          if (beat_cnt_q <= CNT_W'(1)) begin
            state_d    = ST_IDLE;
            beat_cnt_d = '0;
            a_done     = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // D path: purely combinational steering by the source MSB.
  assign d_msb     = s_d_bits[D_MSB];
  assign m_d_valid = {s_d_valid & d_msb, s_d_valid & ~d_msb};
  assign s_d_ready = m_d_ready[d_msb];

  for (genvar g = 0; g < 2; g++) begin : g_m_d
    assign m_d_bits[g] = {s_d_bits[SD_W-1:D_MSB+1], s_d_bits[D_MSB-1:0]};
  end

`ifdef TL_ARB_INFLIGHT_LIMIT_EN
  localparam int IF_W       = $clog2(MAX_INFLIGHT + 1);
  localparam int D_SIZE_LSB = d_size_lsb(SRC_W + 1, DATA_W);
  localparam int D_OPC_LSB  = d_opc_lsb(SRC_W + 1, DATA_W);

  logic [1:0][IF_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0]     d_cnt_q, d_cnt_d;
  logic                 d_hs;
  logic                 d_last;
  logic [7:0]           d_beats;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight_q <= '0;
      d_cnt_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      d_cnt_q    <= d_cnt_d;
    end
  end

  // A response is retired on its last D beat; d_cnt_q counts the beats
  // still owed by a multi-beat AccessAckData.
  always_comb begin
    d_hs    = s_d_valid & s_d_ready;
    d_beats = resp_beats_of(s_d_bits[D_OPC_LSB +: 3], s_d_bits[D_SIZE_LSB +: 3],
                            LGB, MAX_SIZE);
    d_cnt_d = d_cnt_q;
    if (d_cnt_q == '0) begin
      d_last = (d_beats == 8'd1);
    end else begin
      d_last = (d_cnt_q == CNT_W'(1));
    end
    if (d_hs) begin
      if (d_cnt_q == '0) begin
        d_cnt_d = CNT_W'(d_beats - 8'd1);
      end else begin
        d_cnt_d = d_cnt_q - CNT_W'(1);
      end
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    full       = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (a_done && grant_idx == 1'(i) && !(d_hs && d_last && d_msb == 1'(i))) begin
        inflight_d[i] = inflight_q[i] + IF_W'(1);
      end else if (!(a_done && grant_idx == 1'(i)) && d_hs && d_last && d_msb == 1'(i)) begin
        inflight_d[i] = inflight_q[i] - IF_W'(1);
      end
      full[i] = (inflight_q[i] == IF_W'(MAX_INFLIGHT));
    end
  end

  assign busy = (state_q == ST_LOCK) || (inflight_q != '0);
`else
  assign full = 2'b00;
  assign busy = (state_q == ST_LOCK);
`endif

endmodule

// File: tb/tb_tl_ul_a_arbiter_2to1.sv
module tb_tl_ul_a_arbiter_2to1;

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0]       m_a_valid;
  logic [1:0]       m_a_ready;
  logic [1:0][72:0] m_a_bits;
  logic             s_a_valid;
  logic             s_a_ready;
  logic [73:0]      s_a_bits;
  logic             s_d_valid;
  logic             s_d_ready;
  logic [43:0]      s_d_bits;
  logic [1:0]       m_d_valid;
  logic [1:0]       m_d_ready;
  logic [1:0][42:0] m_d_bits;
  logic             busy;

  int n_chk = 0;
  int n_err = 0;

  tl_ul_a_arbiter_2to1 dut (
    .clock     (clock),
    .reset     (reset),
    .m_a_valid (m_a_valid),
    .m_a_ready (m_a_ready),
    .m_a_bits  (m_a_bits),
    .s_a_valid (s_a_valid),
    .s_a_ready (s_a_ready),
    .s_a_bits  (s_a_bits),
    .s_d_valid (s_d_valid),
    .s_d_ready (s_d_ready),
    .s_d_bits  (s_d_bits),
    .m_d_valid (m_d_valid),
    .m_d_ready (m_d_ready),
    .m_d_bits  (m_d_bits),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Master-side A beat: {opcode, param, size, source[2], address[26], mask[4], data[32]}
  function automatic logic [72:0] a_beat(input logic [2:0] opc, input logic [2:0] size,
                                         input logic [1:0] src, input logic [25:0] addr,
                                         input logic [31:0] data);
    return {opc, 3'd0, size, src, addr, 4'hF, data};
  endfunction

  // Expected downstream A beat with the master index inserted above the source.
  function automatic logic [73:0] s_beat(input logic [2:0] opc, input logic [2:0] size,
                                         input logic g, input logic [1:0] src,
                                         input logic [25:0] addr, input logic [31:0] data);
    return {opc, 3'd0, size, g, src, addr, 4'hF, data};
  endfunction

  function automatic logic [43:0] d_beat(input logic [2:0] opc, input logic [2:0] size,
                                         input logic [2:0] src, input logic [31:0] data);
    return {opc, 2'd0, size, src, 1'b0, data};
  endfunction

  function automatic logic [42:0] md_beat(input logic [2:0] opc, input logic [2:0] size,
                                          input logic [1:0] src, input logic [31:0] data);
    return {opc, 2'd0, size, src, 1'b0, data};
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic g;
    reset     = 1'b0;
    m_a_valid = 2'b00;
    m_a_bits  = '0;
    s_a_ready = 1'b0;
    s_d_valid = 1'b0;
    s_d_bits  = '0;
    m_d_ready = 2'b00;

    // Reset state
    repeat (2) tick();
    @(negedge clock);
    check("rst_s_a_valid", s_a_valid, 1'b0);
    check("rst_m_a_ready", m_a_ready, 2'b00);
    check("rst_m_d_valid", m_d_valid, 2'b00);
    check("rst_s_d_ready", s_d_ready, 1'b0);
    check("rst_busy",      busy,      1'b0);
    tick();
    reset = 1'b1;

    // D routing by source MSB
    s_d_valid = 1'b1;
    s_d_bits  = d_beat(3'd1, 3'd2, 3'b110, 32'hD00D_0001);
    m_d_ready = 2'b11;
    @(negedge clock);
    check("d1_valid", m_d_valid, 2'b10);
    check("d1_ready", s_d_ready, 1'b1);
    check("d1_bits",  m_d_bits[1], md_beat(3'd1, 3'd2, 2'b10, 32'hD00D_0001));
    tick();
    m_d_ready = 2'b01;
    @(negedge clock);
    check("d1_stall_ready", s_d_ready, 1'b0);
    check("d1_stall_valid", m_d_valid, 2'b10);
    tick();
    s_d_bits  = d_beat(3'd0, 3'd2, 3'b010, 32'h0);
    m_d_ready = 2'b11;
    @(negedge clock);
    check("d0_valid", m_d_valid, 2'b01);
    check("d0_ready", s_d_ready, 1'b1);
    check("d0_bits",  m_d_bits[0], md_beat(3'd0, 3'd2, 2'b10, 32'h0));
    tick();
    m_d_ready = 2'b10;
    @(negedge clock);
    check("d0_stall_ready", s_d_ready, 1'b0);
    tick();
    s_d_valid = 1'b0;
    m_d_ready = 2'b00;
    reset     = 1'b0;
    tick();
    reset     = 1'b1;

`ifdef TL_ARB_INFLIGHT_LIMIT_EN
    // Outstanding limit: four Gets from M0 with no responses
    s_a_ready   = 1'b1;
    m_a_valid   = 2'b01;
    m_a_bits[0] = a_beat(3'd4, 3'd2, 2'b01, 26'h100, 32'h0);
    m_a_bits[1] = a_beat(3'd4, 3'd2, 2'b10, 26'h200, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("lim_m0_ready", m_a_ready, 2'b01);
      tick();
    end
    m_a_valid = 2'b11;
    @(negedge clock);
    check("lim_m1_bits",  s_a_bits, s_beat(3'd4, 3'd2, 1'b1, 2'b10, 26'h200, 32'h0));
    check("lim_m1_ready", m_a_ready, 2'b10);
    check("lim_busy",     busy, 1'b1);
    tick();
    m_a_valid = 2'b01;
    s_d_valid = 1'b1;
    s_d_bits  = d_beat(3'd1, 3'd2, 3'b000, 32'h5A5A_0000);
    m_d_ready = 2'b01;
    @(negedge clock);
    check("lim_masked", s_a_valid, 1'b0);
    check("lim_d_valid", m_d_valid, 2'b01);
    tick();
    s_d_valid = 1'b0;
    @(negedge clock);
    check("lim_reopen_valid", s_a_valid, 1'b1);
    check("lim_reopen_ready", m_a_ready, 2'b01);
    tick();
    m_a_valid = 2'b00;
`else
    // Round-robin between two Get streams
    s_a_ready   = 1'b1;
    m_a_valid   = 2'b11;
    m_a_bits[0] = a_beat(3'd4, 3'd2, 2'b01, 26'h100, 32'h0);
    m_a_bits[1] = a_beat(3'd4, 3'd2, 2'b10, 26'h200, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      g = (k % 2) == 1;
      check("rr_bits",  s_a_bits, g ? s_beat(3'd4, 3'd2, 1'b1, 2'b10, 26'h200, 32'h0)
                                    : s_beat(3'd4, 3'd2, 1'b0, 2'b01, 26'h100, 32'h0));
      check("rr_ready", m_a_ready, g ? 2'b10 : 2'b01);
      tick();
    end

    // M0 four-beat PutFull locks out M1
    m_a_bits[0] = a_beat(3'd0, 3'd4, 2'b01, 26'h100, 32'hA0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("lock_bits",  s_a_bits, s_beat(3'd0, 3'd4, 1'b0, 2'b01, 26'h100, 32'hA0));
      check("lock_ready", m_a_ready, 2'b01);
      check("lock_busy",  busy, k != 0);
      tick();
    end
    m_a_valid = 2'b10;
    @(negedge clock);
    check("after_lock_bits", s_a_bits, s_beat(3'd4, 3'd2, 1'b1, 2'b10, 26'h200, 32'h0));
    check("after_lock_busy", busy, 1'b0);
    tick();

    // Backpressure during M1 beat 2
    m_a_bits[1] = a_beat(3'd0, 3'd4, 2'b10, 26'h200, 32'hB1);
    @(negedge clock);
    check("m1_b1_ready", m_a_ready, 2'b10);
    tick();
    s_a_ready   = 1'b0;
    m_a_valid   = 2'b11;
    m_a_bits[0] = a_beat(3'd4, 3'd2, 2'b01, 26'h100, 32'h0);
    m_a_bits[1] = a_beat(3'd0, 3'd4, 2'b10, 26'h200, 32'hB2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("bp_valid", s_a_valid, 1'b1);
      check("bp_bits",  s_a_bits, s_beat(3'd0, 3'd4, 1'b1, 2'b10, 26'h200, 32'hB2));
      check("bp_ready", m_a_ready, 2'b00);
      tick();
    end
    s_a_ready = 1'b1;
    for (int b = 2; b <= 4; b++) begin
      m_a_bits[1] = a_beat(3'd0, 3'd4, 2'b10, 26'h200, 32'hB0 + b);
      @(negedge clock);
      check("bp_beat_bits", s_a_bits, s_beat(3'd0, 3'd4, 1'b1, 2'b10, 26'h200, 32'hB0 + b));
      check("bp_beat_ready", m_a_ready, 2'b10);
      tick();
    end
    m_a_valid = 2'b01;
    @(negedge clock);
    check("bp_after_bits",  s_a_bits, s_beat(3'd4, 3'd2, 1'b0, 2'b01, 26'h100, 32'h0));
    check("bp_after_busy",  busy, 1'b0);
    check("bp_after_ready", m_a_ready, 2'b01);
    tick();

    // Oversize Put passes as a single beat
    m_a_bits[0] = a_beat(3'd0, 3'd7, 2'b01, 26'h100, 32'hC7);
    @(negedge clock);
    check("big_bits", s_a_bits, s_beat(3'd0, 3'd7, 1'b0, 2'b01, 26'h100, 32'hC7));
    tick();
    m_a_valid = 2'b00;
    @(negedge clock);
    check("big_busy",  busy, 1'b0);
    check("big_valid", s_a_valid, 1'b0);
    tick();

    // A stalled IDLE beat keeps its grant when the other master arrives
    m_a_valid   = 2'b01;
    m_a_bits[0] = a_beat(3'd4, 3'd2, 2'b01, 26'h100, 32'h0);
    s_a_ready   = 1'b0;
    @(negedge clock);
    check("hold_first", s_a_bits, s_beat(3'd4, 3'd2, 1'b0, 2'b01, 26'h100, 32'h0));
    tick();
    m_a_valid = 2'b11;
    @(negedge clock);
    check("hold_grant", s_a_bits, s_beat(3'd4, 3'd2, 1'b0, 2'b01, 26'h100, 32'h0));
    check("hold_ready", m_a_ready, 2'b00);
    tick();
    s_a_ready = 1'b1;
    @(negedge clock);
    check("hold_accept", m_a_ready, 2'b01);
    tick();
    m_a_valid = 2'b00;

    // Reset in the middle of a four-beat burst
    m_a_valid   = 2'b01;
    m_a_bits[0] = a_beat(3'd0, 3'd4, 2'b01, 26'h100, 32'hE0);
    tick();
    @(negedge clock);
    check("mid_busy", busy, 1'b1);
    tick();
    reset     = 1'b0;
    m_a_valid = 2'b00;
    s_a_ready = 1'b0;
    @(negedge clock);
    check("mid_rst_busy",    busy, 1'b0);
    check("mid_rst_valid",   s_a_valid, 1'b0);
    check("mid_rst_ready",   m_a_ready, 2'b00);
    check("mid_rst_d_valid", m_d_valid, 2'b00);
    tick();
    reset       = 1'b1;
    m_a_valid   = 2'b11;
    m_a_bits[0] = a_beat(3'd4, 3'd2, 2'b01, 26'h100, 32'h0);
    m_a_bits[1] = a_beat(3'd4, 3'd2, 2'b10, 26'h200, 32'h0);
    @(negedge clock);
    check("post_rst_grant", s_a_bits, s_beat(3'd4, 3'd2, 1'b0, 2'b01, 26'h100, 32'h0));
    check("post_rst_busy",  busy, 1'b0);
    tick();
    m_a_valid = 2'b00;
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
